// File: rtl/disp_pkg.sv
// Shared types and defaults for the multiplexed 7-segment scan controller.
// No logic; compile-time definitions only.
// No flow control.
package disp_pkg;

   typedef enum logic {S_BLANK, S_SHOW} scan_state_t;

   localparam int DISP_N_DIGITS     = 4;
   localparam int DISP_REFRESH_DIV  = 50000;
   localparam int DISP_BLANK_CYCLES = 500;

   // Digit index width; a single-digit display still needs a 1-bit index.
   function automatic int dig_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/disp_slot_timer.sv
// Slot counter and digit index: tells the top which digit is scanned and whether it is blanked.
// state/dig valid from the first cycle after reset; frame_end decoded from registers.
// Free-running; no flow control.
module disp_slot_timer
   import disp_pkg::*;
#(
   parameter int N_DIGITS     = DISP_N_DIGITS,
   parameter int REFRESH_DIV  = DISP_REFRESH_DIV,
   parameter int BLANK_CYCLES = DISP_BLANK_CYCLES,
   localparam int DIG_W       = dig_width(N_DIGITS),
   localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [DIG_W-1:0] dig,
   output scan_state_t      state,
   output logic             frame_end
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
   localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(N_DIGITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [DIG_W-1:0] dig_q, dig_nxt;
   scan_state_t      state_q, state_nxt;

   // State register: slot counter, digit index and blank/show phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         dig_q   <= '0;
         state_q <= S_BLANK;
      end else begin
         cnt_q   <= cnt_nxt;
         dig_q   <= dig_nxt;
         state_q <= state_nxt;
      end
   end

   // Next state: count through the slot, advance the digit on wrap; the phase follows the next count.
   always_comb begin
      cnt_nxt = cnt_q + 1'b1;
      dig_nxt = dig_q;
      if (cnt_q == CNT_MAX) begin
         cnt_nxt = '0;
         dig_nxt = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
      end
      state_nxt = (cnt_nxt < BLANK_C) ? S_BLANK : S_SHOW;
   end

   // Outputs: decoded from registers only.
   always_comb begin
      dig       = dig_q;
      state     = state_q;
      frame_end = (dig_q == DIG_MAX) && (cnt_q == CNT_MAX);
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan controller: shows one nibble at a time with active-low digit enables, blanking and zero suppression.
// load -> pending next cycle; new value on nibble at the first cycle of the next frame.
// No backpressure; a newer load overwrites an unapplied one.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int N_DIGITS     = DISP_N_DIGITS,
   parameter int REFRESH_DIV  = DISP_REFRESH_DIV,
   parameter int BLANK_CYCLES = DISP_BLANK_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic                  lzb,
   output logic [3:0]            nibble,
   output logic [N_DIGITS-1:0]   an_n,
   output logic                  pending,
   output logic                  frame_done
);

   localparam int DIG_W = dig_width(N_DIGITS);

   logic [DIG_W-1:0]      dig;
   scan_state_t           state;
   logic                  frame_end;
   logic [4*N_DIGITS-1:0] active_q, shadow_q;
   logic                  pending_q;
   logic                  lzb_q;
   logic [N_DIGITS-1:0]   sup;
   logic                  all_zero;

   disp_slot_timer #(
      .N_DIGITS     (N_DIGITS),
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .dig       (dig),
      .state     (state),
      .frame_end (frame_end)
   );

   // Value capture: loads park in shadow and apply at the frame boundary so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         lzb_q     <= 1'b0;
      end else begin
         lzb_q <= lzb;
         if (load) begin
            shadow_q <= value;
            if (frame_end) begin
               active_q  <= value;
               pending_q <= 1'b0;
            end else begin
               pending_q <= 1'b1;
            end
         end else if (frame_end && pending_q) begin
            active_q  <= shadow_q;
            pending_q <= 1'b0;
         end
      end
   end

   // Suppression mask: digit i>0 is suppressed when it and every higher digit are zero.
   always_comb begin
      sup      = '0;
      all_zero = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         all_zero = all_zero & (active_q[4*i +: 4] == 4'h0);
         sup[i]   = all_zero;
      end
   end

   // Output decode: nibble tracks the scanned digit, its enable drops only in the show phase.
   always_comb begin
      nibble     = active_q[4*int'(dig) +: 4];
      an_n       = '1;
      if (state == S_SHOW && !(lzb_q && sup[dig])) begin
         an_n[dig] = 1'b0;
      end
      pending    = pending_q;
      frame_done = frame_end;
   end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for a multi-digit 7-segment display. Holds a packed BCD/hex value and presents one 4-bit nibble at a time to the shared `disp_deco` segment decoder, while driving active-low digit enables. Includes per-slot blanking (anti-ghosting), tear-free frame-synchronous value update and optional leading-zero suppression. Sits between the value-producing logic and the decoder/board pins.

## Interface

- `N_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; ≥ 2.
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all digits off; 1 ≤ BLANK_CYCLES < REFRESH_DIV.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `load`  in  1: one-cycle request to capture `value`.
- `value`  in  4*N_DIGITS: packed digits; digit i = `value[4i+3:4i]`, digit 0 least significant.
- `lzb`  in  1: leading-zero blanking enable (level).
- `nibble`  out  4: current digit code to decoder (bit3→x, bit2→y, bit1→z, bit0→w).
- `an_n`  out  N_DIGITS: active-low digit enables; at most one low at any time.
- `pending`  out  1: a loaded value waits for the frame boundary.
- `frame_done`  out  1: one-cycle pulse on the last cycle of each frame.

## Operation

- Registers: `active` and `shadow` (4*N_DIGITS each), digit index `dig` (0..N_DIGITS-1), slot counter `cnt` (0..REFRESH_DIV-1, width $clog2(REFRESH_DIV)), `pending`.
- Reset: `active`=`shadow`=0, `dig`=0, `cnt`=0, `pending`=0; outputs `nibble`=0, `an_n`=all ones, `frame_done`=0.
- FSM per slot: S_BLANK while `cnt` < BLANK_CYCLES, S_SHOW otherwise. `cnt` increments each cycle; at REFRESH_DIV-1 wraps to 0 and `dig` advances, wrapping N_DIGITS-1→0.
- S_BLANK: `an_n` all ones; `nibble` = `active` digit `dig`.
- S_SHOW: `an_n[dig]`=0, others 1; `nibble` unchanged within slot.
- Leading-zero blanking: with `lzb`=1, digit i>0 is suppressed (its `an_n` bit stays 1 in S_SHOW) when digits i..N_DIGITS-1 of `active` are all zero. Digit 0 is never suppressed.
- Frame boundary: cycle with `dig`=N_DIGITS-1 and `cnt`=REFRESH_DIV-1; `frame_done`=1 only there.
- Load: `load`=1 copies `value`→`shadow`, sets `pending`. At the boundary edge `active`←`shadow`, `pending`←0.
- Load on the boundary cycle itself: `value` goes directly to `active`, `pending` stays 0.
- Repeated loads before a boundary: last one wins; earlier ones are discarded.
- N_DIGITS=1: every slot is a frame; `frame_done` pulses each REFRESH_DIV cycles.

## Timing

- All outputs are registered or decoded from registers only; no combinational input→output path.
- `load` sampled on the rising edge; `pending` high the following cycle.
- New value visible on `nibble` in the first cycle of digit 0 after the boundary (S_BLANK of the next frame).
- Frame period = N_DIGITS*REFRESH_DIV cycles; digit on-time = REFRESH_DIV-BLANK_CYCLES per slot.
- `rst_n` asserted mid-frame: all state returns to reset values immediately (asynchronously); `an_n` goes all ones without waiting for a clock edge. First cycle after release = digit 0, `cnt`=0.

## Structure

- Package `disp_pkg`: `typedef enum logic {S_BLANK, S_SHOW} scan_state_t`; default constants `DISP_N_DIGITS`, `DISP_REFRESH_DIV`, `DISP_BLANK_CYCLES`.
- One sub-module, `disp_slot_timer`: slot counter + digit index, providing `dig`, `state`, `frame_end`. Load/shadow logic, blanking and output registers stay in the top.
- `disp_deco` is instantiated by the integrating level, not inside this block.

## Test plan

(N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, frame=32 cycles.)
- Reset release, no load → `an_n`=4'b1111 cycles 0–1, 4'b1110 cycles 2–7, then 4'b1101 at 10–15; `nibble`=0 throughout; `frame_done` at cycle 31 only.
- `load` value=16'h1234 at cycle 5 → `pending`=1 cycles 6–31; `nibble` 0 until cycle 32, then 4,3,2,1 on slots starting 32,40,48,56.
- Loads 16'hAAAA at cycle 3 and 16'h5555 at cycle 20 → frame 2 shows only 5s; A never appears.
- `load` 16'h9876 exactly at cycle 31 → `pending` stays 0; `nibble`=6 at cycle 32.
- `lzb`=1, value=16'h0050 → digits 2,3 `an_n` stay high all slots; digit 1 shows 5, digit 0 shows 0 and enables; value=16'h0000 → only digit 0 enables.
- `rst_n` low at cycle 45 (digit 1 in S_SHOW) → `an_n`=4'b1111 same cycle, asynchronously; `active`=0; after release scan restarts at digit 0, `cnt`=0.
